// File: rtl/formula_pipe_credit_adapter_if.sv
// Bus bundle for the formula pipe credit adapter: upstream args, pipe issue/result, downstream results.
// The adapter connects through the slave modport; the environment drives the master side.
interface formula_pipe_credit_adapter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             up_vld;
    logic             up_rdy;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic [WIDTH-1:0] up_c;

    logic             pipe_arg_vld;
    logic [WIDTH-1:0] pipe_a;
    logic [WIDTH-1:0] pipe_b;
    logic [WIDTH-1:0] pipe_c;
    logic             pipe_res_vld;
    logic [WIDTH-1:0] pipe_res;

    logic             down_vld;
    logic             down_rdy;
    logic [WIDTH-1:0] down_data;

    modport slave (
        input  up_vld, up_a, up_b, up_c, pipe_res_vld, pipe_res, down_rdy,
        output up_rdy, pipe_arg_vld, pipe_a, pipe_b, pipe_c, down_vld, down_data
    );

    modport master (
        output up_vld, up_a, up_b, up_c, pipe_res_vld, pipe_res, down_rdy,
        input  up_rdy, pipe_arg_vld, pipe_a, pipe_b, pipe_c, down_vld, down_data
    );
endinterface

// File: rtl/formula_pipe_credit_adapter.sv
// Credit-based valid/ready wrapper around a fixed-latency, no-backpressure formula pipe.
// Optional sticky overflow flag err_ovf is enabled with `define FORMULA_ADAPTER_ERR_EN.
module formula_pipe_credit_adapter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    formula_pipe_credit_adapter_if.slave bus
`ifdef FORMULA_ADAPTER_ERR_EN
    ,
    output logic err_ovf
`endif
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]    credits_q, credits_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic empty, full, issue, pop, push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign issue = bus.up_vld & bus.up_rdy;
    assign pop   = bus.down_vld & bus.down_rdy;
    // A push into a full FIFO only lands if the head is leaving in the same cycle.
    assign push  = bus.pipe_res_vld & (~full | pop);

    assign bus.up_rdy       = (credits_q != '0);
    assign bus.pipe_arg_vld = issue;
    assign bus.pipe_a       = bus.up_a;
    assign bus.pipe_b       = bus.up_b;
    assign bus.pipe_c       = bus.up_c;
    assign bus.down_vld     = ~empty;
    assign bus.down_data    = mem_q[rd_ptr_q[AW-1:0]];

    // Credit and pointer next-state.
    always_comb begin
        credits_d = credits_q;
        wr_ptr_d  = wr_ptr_q + PW'(push);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        if (issue && !pop) begin
            credits_d = credits_q - CW'(1);
        end else if (pop && !issue && (credits_q != CW'(FIFO_DEPTH))) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits_q <= CW'(FIFO_DEPTH);
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            credits_q <= credits_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Result storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.pipe_res;
        end
    end

`ifdef FORMULA_ADAPTER_ERR_EN
    logic err_ovf_q, err_ovf_d;

    always_comb begin
        err_ovf_d = err_ovf_q;
        if (bus.pipe_res_vld && full && !pop) begin
            err_ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_ovf_q <= 1'b0;
        end else begin
            err_ovf_q <= err_ovf_d;
        end
    end

    assign err_ovf = err_ovf_q;
`endif
endmodule
